mdu_seq: RTL

- Multi-cycle multiply/divide sequencer for the CPU's MULT/MULTU/DIV/DIVU instructions.
- Time-shares one instance of the team's 32-bit adder ADC32 (A, B, C0 -> S[32:0]) for operand negation, shift-add multiply, restoring divide and result negation.
- Owns the HI/LO result registers; the core stalls on busy and reads hi/lo after done.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_seq_if.sv | 30 +++
 rtl/mdu_seq_adc32.sv | 16 +
 rtl/mdu_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_pkg : shared encodings for the multiply/divide sequencer              |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package mdu_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_NEG_A  = 3'd1,
        S_NEG_B  = 3'd2,
        S_ITER   = 3'd3,
        S_FIX_LO = 3'd4,
        S_FIX_HI = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_seq_if : core <-> multiply/divide sequencer request/result bundle     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface mdu_seq_if;
    import mdu_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );

endinterface : mdu_seq_if
`default_nettype wire

// File: rtl/mdu_seq_adc32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_seq_adc32 : the ADC32 adder, S[32:0] = A + B + C0                     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mdu_seq_adc32 (
    input  wire logic [31:0] a_i,
    input  wire logic [31:0] b_i,
    input  wire logic        c0_i,
    output logic      [32:0] s_o
);

    assign s_o = {1'b0, a_i} + {1'b0, b_i} + {32'd0, c0_i};

endmodule : mdu_seq_adc32
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_seq : MULT/MULTU/DIV/DIVU sequencer sharing one ADC32, owns HI/LO     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mdu_seq #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    mdu_seq_if.slave  bus
);
    import mdu_pkg::*;

    localparam int CW = $clog2(ITERS);

    state_t          state_q;
    logic            busy_q, done_q, dbz_q;
    logic            bz_q, sa_q, sb_q, c_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q, opa_q, opb_q, hi_q, lo_q;
    logic [CW-1:0]   cnt_q;

    logic [XLEN-1:0] w_add_a, w_add_b;
    logic            w_add_c0;
    logic [XLEN:0]   w_sum;

    logic            w_is_div, w_dz, w_neg_lo, w_neg_hi;
    logic [XLEN-1:0] w_rem_shift, w_opb_fixed;

    assign w_is_div    = op_q[1];
    assign w_dz        = w_is_div & bz_q;
    assign w_rem_shift = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    assign w_opb_fixed = sb_q ? w_sum[XLEN-1:0] : opb_q;
    // Quotient/product sign follows sa^sb; remainder takes the dividend sign.
    assign w_neg_lo    = (sa_q ^ sb_q) & ~w_dz;
    assign w_neg_hi    = (w_is_div ? sa_q : (sa_q ^ sb_q)) & ~w_dz;

    always_comb begin
        w_add_a  = '0;
        w_add_b  = '0;
        w_add_c0 = 1'b0;
        case (state_q)
            S_NEG_A: begin
                w_add_a  = ~opa_q;
                w_add_c0 = 1'b1;
            end
            S_NEG_B: begin
                w_add_a  = ~opb_q;
                w_add_c0 = 1'b1;
            end
            S_ITER: begin
                if (w_is_div) begin
                    w_add_a  = w_rem_shift;
                    w_add_b  = ~opb_q;
                    w_add_c0 = 1'b1;
                end else begin
                    w_add_a  = hi_q;
                    w_add_b  = opa_q;
                end
            end
            S_FIX_LO: begin
                w_add_a  = ~lo_q;
                w_add_c0 = 1'b1;
            end
            S_FIX_HI: begin
                // Multiply chains the low-word carry to form a 64-bit negate.
                w_add_a  = ~hi_q;
                w_add_c0 = w_is_div ? 1'b1 : c_q;
            end
            default: ;
        endcase
    end

    mdu_seq_adc32 u_adc32 (
        .a_i  (w_add_a),
        .b_i  (w_add_b),
        .c0_i (w_add_c0),
        .s_o  (w_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            bz_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            c_q     <= 1'b0;
            op_q    <= 2'b00;
            a_q     <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        a_q     <= bus.a;
                        opa_q   <= bus.a;
                        opb_q   <= bus.b;
                        sa_q    <= bus.op[0] & bus.a[XLEN-1];
                        sb_q    <= bus.op[0] & bus.b[XLEN-1];
                        bz_q    <= (bus.b == '0);
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_NEG_A;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_NEG_A: begin
                    if (sa_q) opa_q <= w_sum[XLEN-1:0];
                    state_q <= S_NEG_B;
                end
                S_NEG_B: begin
                    opb_q   <= w_opb_fixed;
                    hi_q    <= '0;
                    lo_q    <= w_is_div ? opa_q : w_opb_fixed;
                    cnt_q   <= '0;
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    if (w_is_div) begin
                        if (hi_q[XLEN-1] | w_sum[XLEN]) begin
                            hi_q <= w_sum[XLEN-1:0];
                            lo_q <= {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_q <= w_rem_shift;
                            lo_q <= {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else if (lo_q[0]) begin
                        hi_q <= w_sum[XLEN:1];
                        lo_q <= {w_sum[0], lo_q[XLEN-1:1]};
                    end else begin
                        hi_q <= {1'b0, hi_q[XLEN-1:1]};
                        lo_q <= {hi_q[0], lo_q[XLEN-1:1]};
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(ITERS - 1)) state_q <= S_FIX_LO;
                end
                S_FIX_LO: begin
                    if (w_neg_lo) lo_q <= w_sum[XLEN-1:0];
                    c_q     <= w_sum[XLEN];
                    state_q <= S_FIX_HI;
                end
                S_FIX_HI: begin
                    if (w_dz) begin
                        hi_q  <= a_q;
                        lo_q  <= '1;
                        dbz_q <= 1'b1;
                    end else if (w_neg_hi) begin
                        hi_q <= w_sum[XLEN-1:0];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule : mdu_seq
`default_nettype wire
